// File: rtl/barrel_shift_sequencer.sv
// Multi-pass sequencer driving an external combinational WIDTH-bit barrel shifter.
// Optional macro BARREL_SHIFT_SEQ_SAT_SHORTCUT_EN: amounts >= WIDTH complete immediately with zero result.
module barrel_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_left,
  output logic [WIDTH-1:0] sh_data_in,
  output logic [SH_W-1:0]  sh_shift_amount,
  output logic             sh_shift_left,
  input  logic [WIDTH-1:0] sh_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] MAX_PASS = AMT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] rem;
  logic             dir;
  logic [AMT_W-1:0] chunk;

  always_comb begin
    chunk = rem;
    if (rem > MAX_PASS) chunk = MAX_PASS;
  end

  assign in_ready        = rst_n && (state == IDLE);
  assign sh_data_in      = work;
  assign sh_shift_left   = dir;
  assign sh_shift_amount = (state == SHIFT) ? chunk[SH_W-1:0] : '0;
  assign out_valid       = (state == DONE);
  assign out_data        = (state == DONE) ? work : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            rem  <= in_amount;
            dir  <= in_left;
            if (in_amount == '0) begin
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
`ifdef BARREL_SHIFT_SEQ_SAT_SHORTCUT_EN
            // Every bit is shifted out anyway; skip the passes entirely.
            if (in_amount >= AMT_W'(WIDTH)) begin
              work  <= '0;
              rem   <= '0;
              state <= DONE;
            end
`endif
          end
        end
        SHIFT: begin
          work <= sh_data_out;
          rem  <= rem - chunk;
          if (rem == chunk) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
